// File: rtl/halt_controller.sv
// ---------------------------------------------------------------------------
// halt_controller
//
// Memory-mapped exit / cycle-count peripheral on the CPU data bus. A store to
// the EXIT register is turned into a registered, held halt request (isHalt)
// with the stored value reported on ret_val. A free-running 32-bit cycle
// counter can be read over the 16-bit bus. A watchdog forces a halt if the
// program never exits.
//
// Register map (word offsets from BASE_ADDR):
//   0 EXIT    write only, reads return 0
//   1 CYC_LO  read count[15:0], snapshot count[31:16] into the shadow
//   2 CYC_HI  read the shadow
//   3 STATUS  read {14'b0, timeout, isHalt}
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   wen      write strobe (one cycle)
//   waddr    write word address
//   wdata    write data
//   ren      read strobe
//   raddr    read word address
//   rdata    registered read data, valid the cycle after ren, held otherwise
//   isHalt   halt request to the monitor, held until reset
//   ret_val  program return value, stable while isHalt is set
//   timeout  set together with isHalt when the watchdog caused the halt
// ---------------------------------------------------------------------------
module halt_controller #(
    parameter logic [15:0] BASE_ADDR    = 16'hFFF0,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned MAX_CYCLES   = 500000,
    parameter logic [15:0] TIMEOUT_CODE = 16'h00FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wen,
    input  logic [15:0] waddr,
    input  logic [15:0] wdata,
    input  logic        ren,
    input  logic [15:0] raddr,
    output logic [15:0] rdata,
    output logic        isHalt,
    output logic [15:0] ret_val,
    output logic        timeout
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // The drain counter holds DRAIN_CYCLES-1 on entry to DRAIN, so the halt
    // lands DRAIN_CYCLES edges after the edge that accepted the EXIT write.
    localparam logic [7:0]  DRAIN_LOAD = (DRAIN_CYCLES == 0) ? 8'd0 : 8'(DRAIN_CYCLES - 1);
    localparam bit          WD_EN      = (MAX_CYCLES != 0);
    localparam logic [31:0] WD_LAST    = 32'(MAX_CYCLES - 1);

    localparam logic [15:0] ADDR_EXIT   = BASE_ADDR;
    localparam logic [15:0] ADDR_CYC_LO = BASE_ADDR + 16'd1;
    localparam logic [15:0] ADDR_CYC_HI = BASE_ADDR + 16'd2;
    localparam logic [15:0] ADDR_STATUS = BASE_ADDR + 16'd3;

    state_t      state;
    logic [31:0] count;
    logic [15:0] shadow;
    logic [7:0]  drain_cnt;

    logic exit_wr;
    logic wd_hit;

    always_comb begin
        exit_wr = wen && (waddr == ADDR_EXIT);
        wd_hit  = WD_EN && (count == WD_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            count     <= 32'd0;
            shadow    <= 16'd0;
            drain_cnt <= 8'd0;
            rdata     <= 16'd0;
            isHalt    <= 1'b0;
            ret_val   <= 16'd0;
            timeout   <= 1'b0;
        end else begin
            // Read port: serviced in every state, sees pre-edge values.
            if (ren) begin
                if (raddr == ADDR_CYC_LO) begin
                    rdata  <= count[15:0];
                    // Latch the upper half now so a later CYC_HI read is
                    // coherent with this low half even across a carry.
                    shadow <= count[31:16];
                end else if (raddr == ADDR_CYC_HI) begin
                    rdata <= shadow;
                end else if (raddr == ADDR_STATUS) begin
                    rdata <= {14'b0, timeout, isHalt};
                end else begin
                    rdata <= 16'd0;
                end
            end

            if (state != HALTED) begin
                count <= count + 32'd1;
            end

            case (state)
                RUN: begin
                    // EXIT takes priority over a watchdog expiry in the same cycle.
                    if (exit_wr) begin
                        ret_val <= wdata;
                        if (DRAIN_CYCLES == 0) begin
                            state  <= HALTED;
                            isHalt <= 1'b1;
                        end else begin
                            drain_cnt <= DRAIN_LOAD;
                            state     <= DRAIN;
                        end
                    end else if (wd_hit) begin
                        ret_val <= TIMEOUT_CODE;
                        timeout <= 1'b1;
                        isHalt  <= 1'b1;
                        state   <= HALTED;
                    end
                end
                DRAIN: begin
                    // Further EXIT writes and the watchdog are ignored here.
                    if (drain_cnt == 8'd0) begin
                        state  <= HALTED;
                        isHalt <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 8'd1;
                    end
                end
                default: begin
                    // HALTED: terminal until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_halt_controller.sv
// ---------------------------------------------------------------------------
// tb_halt_controller
//
// Two instances share one stimulus bus:
//   dut_a : DRAIN_CYCLES=4, MAX_CYCLES=100 (drain and watchdog behaviour)
//   dut_b : DRAIN_CYCLES=0, MAX_CYCLES=0   (immediate halt, long counter runs)
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, away from the rising clock edge.
// ---------------------------------------------------------------------------
module tb_halt_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wen = 1'b0;
    logic [15:0] waddr = 16'd0;
    logic [15:0] wdata = 16'd0;
    logic        ren = 1'b0;
    logic [15:0] raddr = 16'd0;

    logic [15:0] a_rdata, a_ret;
    logic        a_isHalt, a_timeout;
    logic [15:0] b_rdata, b_ret;
    logic        b_isHalt, b_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    halt_controller #(
        .BASE_ADDR(16'hFFF0), .DRAIN_CYCLES(4), .MAX_CYCLES(100), .TIMEOUT_CODE(16'h00FF)
    ) dut_a (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr(raddr), .rdata(a_rdata),
        .isHalt(a_isHalt), .ret_val(a_ret), .timeout(a_timeout)
    );

    halt_controller #(
        .BASE_ADDR(16'hFFF0), .DRAIN_CYCLES(0), .MAX_CYCLES(0), .TIMEOUT_CODE(16'h00FF)
    ) dut_b (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr(raddr), .rdata(b_rdata),
        .isHalt(b_isHalt), .ret_val(b_ret), .timeout(b_timeout)
    );

    typedef struct {
        logic        wen;
        logic [15:0] waddr;
        logic [15:0] wdata;
        logic        ren;
        logic [15:0] raddr;
        logic        halt;
        logic [15:0] ret;
        logic        to;
        logic [15:0] rdata;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic w, input logic [15:0] wa, input logic [15:0] wd,
                                input logic r, input logic [15:0] ra,
                                input logic h, input logic [15:0] rv, input logic t,
                                input logic [15:0] rd);
        vec_t v;
        v.wen = w; v.waddr = wa; v.wdata = wd; v.ren = r; v.raddr = ra;
        v.halt = h; v.ret = rv; v.to = t; v.rdata = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_bus();
        wen = 1'b0; waddr = 16'd0; wdata = 16'd0; ren = 1'b0; raddr = 16'd0;
    endtask

    // Leaves the bench on a falling edge with rst just released; the next
    // rising edge is the first one seen by the design with count == 0.
    task automatic reset_dut();
        idle_bus();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_isHalt", {31'd0, a_isHalt}, 32'd0);
        chk("rst_ret", {16'd0, a_ret}, 32'd0);
        chk("rst_timeout", {31'd0, a_timeout}, 32'd0);
        chk("rst_rdata", {16'd0, a_rdata}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic exit_write(input logic [15:0] val);
        wen = 1'b1; waddr = 16'hFFF0; wdata = val;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;

        // Row i is applied before rising edge i+1 after reset (count == i).
        // EXIT accepted at row 5 -> isHalt on the 4th following edge (row 9).
        tbl[0]  = mk(1, 16'hFFF1, 16'h1234, 1, 16'hFFEF, 0, 16'h0000, 0, 16'h0000);
        tbl[1]  = mk(1, 16'hFFF2, 16'h1111, 1, 16'hFFF3, 0, 16'h0000, 0, 16'h0000);
        tbl[2]  = mk(1, 16'hFFF3, 16'h2222, 1, 16'hFFF0, 0, 16'h0000, 0, 16'h0000);
        tbl[3]  = mk(1, 16'hFFEF, 16'h3333, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        tbl[4]  = mk(0, 16'h0000, 16'h0000, 1, 16'hFFF1, 0, 16'h0000, 0, 16'h0004);
        tbl[5]  = mk(1, 16'hFFF0, 16'h002A, 1, 16'hFFF3, 0, 16'h002A, 0, 16'h0000);
        tbl[6]  = mk(1, 16'hFFF0, 16'h0007, 0, 16'h0000, 0, 16'h002A, 0, 16'h0000);
        tbl[7]  = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h002A, 0, 16'h0000);
        tbl[8]  = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h002A, 0, 16'h0000);
        tbl[9]  = mk(0, 16'h0000, 16'h0000, 1, 16'hFFF3, 1, 16'h002A, 0, 16'h0000);
        tbl[10] = mk(0, 16'h0000, 16'h0000, 1, 16'hFFF3, 1, 16'h002A, 0, 16'h0001);
        tbl[11] = mk(1, 16'hFFF0, 16'h0099, 0, 16'h0000, 1, 16'h002A, 0, 16'h0001);
        tbl[12] = mk(0, 16'h0000, 16'h0000, 1, 16'hFFF1, 1, 16'h002A, 0, 16'h000A);

        // ---------------- table: map edges + normal exit ----------------
        reset_dut();
        for (int i = 0; i < 13; i++) begin
            wen = tbl[i].wen; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
            ren = tbl[i].ren; raddr = tbl[i].raddr;
            @(negedge clk);
            chk($sformatf("tbl%0d_isHalt", i), {31'd0, a_isHalt}, {31'd0, tbl[i].halt});
            chk($sformatf("tbl%0d_ret", i), {16'd0, a_ret}, {16'd0, tbl[i].ret});
            chk($sformatf("tbl%0d_timeout", i), {31'd0, a_timeout}, {31'd0, tbl[i].to});
            chk($sformatf("tbl%0d_rdata", i), {16'd0, a_rdata}, {16'd0, tbl[i].rdata});
            chk($sformatf("tbl%0d_b_isHalt", i), {31'd0, b_isHalt}, (i >= 5) ? 32'd1 : 32'd0);
        end
        idle_bus();
        chk("b_ret", {16'd0, b_ret}, 32'h002A);
        chk("b_timeout", {31'd0, b_timeout}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_isHalt", {31'd0, a_isHalt}, 32'd1);
            chk("hold_ret", {16'd0, a_ret}, 32'h002A);
        end

        // ---------------- double exit ----------------
        reset_dut();
        exit_write(16'h0005);
        @(negedge clk);
        exit_write(16'h0007);
        @(negedge clk);
        idle_bus();
        chk("dbl_ret_early", {16'd0, a_ret}, 32'h0005);
        repeat (2) @(negedge clk);
        chk("dbl_isHalt_pre", {31'd0, a_isHalt}, 32'd0);
        @(negedge clk);
        chk("dbl_isHalt", {31'd0, a_isHalt}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_isHalt !== 1'b1 || a_ret !== 16'h0005) seen = 1'b1;
        end
        chk("dbl_single_halt", {31'd0, seen}, 32'd0);

        // ---------------- watchdog ----------------
        reset_dut();
        repeat (99) @(negedge clk);
        chk("wd_isHalt_99", {31'd0, a_isHalt}, 32'd0);
        @(negedge clk);
        chk("wd_isHalt_100", {31'd0, a_isHalt}, 32'd1);
        chk("wd_timeout", {31'd0, a_timeout}, 32'd1);
        chk("wd_ret", {16'd0, a_ret}, 32'h00FF);
        chk("wd_b_isHalt", {31'd0, b_isHalt}, 32'd0);
        repeat (5) @(negedge clk);
        ren = 1'b1; raddr = 16'hFFF1;
        @(negedge clk);
        chk("wd_count_frozen", {16'd0, a_rdata}, 32'd100);
        raddr = 16'hFFF3;
        @(negedge clk);
        chk("wd_status", {16'd0, a_rdata}, 32'h0003);
        idle_bus();

        // ---------------- watchdog vs EXIT in the same cycle ----------------
        reset_dut();
        repeat (99) @(negedge clk);
        exit_write(16'h1234);
        @(negedge clk);
        idle_bus();
        chk("wdx_isHalt_early", {31'd0, a_isHalt}, 32'd0);
        chk("wdx_timeout_early", {31'd0, a_timeout}, 32'd0);
        chk("wdx_ret_early", {16'd0, a_ret}, 32'h1234);
        repeat (3) @(negedge clk);
        chk("wdx_isHalt_pre", {31'd0, a_isHalt}, 32'd0);
        @(negedge clk);
        chk("wdx_isHalt", {31'd0, a_isHalt}, 32'd1);
        chk("wdx_timeout", {31'd0, a_timeout}, 32'd0);
        chk("wdx_ret", {16'd0, a_ret}, 32'h1234);

        // ---------------- async reset mid-DRAIN ----------------
        reset_dut();
        exit_write(16'h0BAD);
        @(negedge clk);
        idle_bus();
        chk("ar_ret_latched", {16'd0, a_ret}, 32'h0BAD);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_ret_cleared", {16'd0, a_ret}, 32'd0);
        chk("ar_isHalt_cleared", {31'd0, a_isHalt}, 32'd0);
        chk("ar_b_isHalt_cleared", {31'd0, b_isHalt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_isHalt !== 1'b0) seen = 1'b1;
        end
        chk("ar_no_halt_50", {31'd0, seen}, 32'd0);
        exit_write(16'h0003);
        @(negedge clk);
        idle_bus();
        repeat (3) @(negedge clk);
        chk("ar_new_isHalt_pre", {31'd0, a_isHalt}, 32'd0);
        @(negedge clk);
        chk("ar_new_isHalt", {31'd0, a_isHalt}, 32'd1);
        chk("ar_new_ret", {16'd0, a_ret}, 32'h0003);
        chk("ar_new_timeout", {31'd0, a_timeout}, 32'd0);

        // ---------------- cycle counter read coherency (dut_b) ----------------
        reset_dut();
        @(negedge clk);
        force dut_b.count = 32'h0001_FFFF;
        ren = 1'b1; raddr = 16'hFFF1;
        #1;
        chk("coh_rdata_latency", {16'd0, b_rdata}, 32'd0);
        @(negedge clk);
        chk("coh_lo", {16'd0, b_rdata}, 32'h0000_FFFF);
        release dut_b.count;
        ren = 1'b0; raddr = 16'd0;
        @(negedge clk);
        chk("coh_rdata_hold", {16'd0, b_rdata}, 32'h0000_FFFF);
        ren = 1'b1; raddr = 16'hFFF2;
        @(negedge clk);
        chk("coh_hi", {16'd0, b_rdata}, 32'h0000_0001);
        idle_bus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
